// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Turns a one-cycle fetch strobe from the fetch stage into a single system-bus
// read, stalls the fetch stage while the read is outstanding and returns the
// fetched word in a register. Misaligned fetch addresses are rejected without
// touching the bus. A watchdog turns a bus that never answers into a bus
// error that completes as a NOP.
//
// Handshake: i_rd_cmd is a strobe sampled only in IDLE. While o_busy is high
// the fetch stage must hold off; a strobe seen in WAIT is dropped. o_bus_rd is
// held with a stable o_bus_addr until the cycle in which i_bus_ack or
// i_bus_err is sampled high (or the watchdog fires); completions seen while
// no read is outstanding are ignored.
//
// Parameters
//   BUS_TIMEOUT  max WAIT cycles without completion before a timeout error;
//                0 disables the watchdog.
//
// Ports
//   clk          clock, all state changes on rising edge
//   nrst         asynchronous active-low reset
//   i_addr       fetch address from the fetch stage
//   i_rd_cmd     one-cycle fetch request strobe
//   o_instr_dat  fetched instruction (registered, NOP on error)
//   o_busy       stall request to the fetch stage (combinational)
//   o_err_align  one-cycle misaligned-fetch pulse
//   o_err_bus    one-cycle bus-error / timeout pulse
//   o_bus_addr   system-bus read address (registered)
//   o_bus_rd     system-bus read request
//   i_bus_data   system-bus read data, valid with i_bus_ack
//   i_bus_ack    system-bus read completion
//   i_bus_err    system-bus error completion
// ---------------------------------------------------------------------------
module ifu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] i_addr,
    input  logic        i_rd_cmd,
    output logic [31:0] o_instr_dat,
    output logic        o_busy,
    output logic        o_err_align,
    output logic        o_err_bus,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_rd,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_ack,
    input  logic        i_bus_err
);

    // Counter holds values 0..BUS_TIMEOUT; keep at least one bit when the
    // watchdog is disabled so the declarations stay legal.
    localparam int unsigned CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam bit          TIMEOUT_EN = (BUS_TIMEOUT != 0);
    // The timeout fires in the WAIT cycle whose increment would reach
    // BUS_TIMEOUT, so o_bus_rd is high for exactly BUS_TIMEOUT cycles.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [31:0]      NOP     = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_align_q, err_align_d;
    logic              err_bus_q, err_bus_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              aligned;
    logic              timeout_hit;

    assign aligned     = (i_addr[1:0] == 2'b00);
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            bus_addr_q  <= '0;
            instr_q     <= NOP;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            instr_q     <= instr_d;
            err_align_q <= err_align_d;
            err_bus_q   <= err_bus_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        instr_d     = instr_q;
        err_align_d = 1'b0;
        err_bus_d   = 1'b0;
        cnt_d       = cnt_q;
        o_busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Bus completions are not looked at here: nothing is outstanding.
                if (i_rd_cmd) begin
                    if (aligned) begin
                        bus_addr_d = i_addr;
                        cnt_d      = '0;
                        state_d    = ST_WAIT;
                        o_busy     = 1'b1;
                    end else begin
                        err_align_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                // Error beats ack when both arrive together; a real completion
                // beats the watchdog in the same cycle.
                if (i_bus_err) begin
                    instr_d   = NOP;
                    err_bus_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (i_bus_ack) begin
                    instr_d = i_bus_data;
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    instr_d   = NOP;
                    err_bus_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_bus_rd    = (state_q == ST_WAIT);
    assign o_bus_addr  = bus_addr_q;
    assign o_instr_dat = instr_q;
    assign o_err_align = err_align_q;
    assign o_err_bus   = err_bus_q;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu.
// u_dut runs with the default watchdog, u_dut_to with BUS_TIMEOUT=4; both see
// the same inputs. Inputs are driven 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ifu;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] i_addr;
  logic        i_rd_cmd;
  logic [31:0] i_bus_data;
  logic        i_bus_ack;
  logic        i_bus_err;

  logic [31:0] o_instr_dat, o_bus_addr;
  logic        o_busy, o_err_align, o_err_bus, o_bus_rd;
  logic [31:0] t_instr_dat, t_bus_addr;
  logic        t_busy, t_err_align, t_err_bus, t_bus_rd;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_instr;
  logic [31:0] exp_q[$];

  ifu u_dut (
    .clk(clk), .nrst(nrst), .i_addr(i_addr), .i_rd_cmd(i_rd_cmd),
    .o_instr_dat(o_instr_dat), .o_busy(o_busy), .o_err_align(o_err_align),
    .o_err_bus(o_err_bus), .o_bus_addr(o_bus_addr), .o_bus_rd(o_bus_rd),
    .i_bus_data(i_bus_data), .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err)
  );

  ifu #(.BUS_TIMEOUT(4)) u_dut_to (
    .clk(clk), .nrst(nrst), .i_addr(i_addr), .i_rd_cmd(i_rd_cmd),
    .o_instr_dat(t_instr_dat), .o_busy(t_busy), .o_err_align(t_err_align),
    .o_err_bus(t_err_bus), .o_bus_addr(t_bus_addr), .o_bus_rd(t_bus_rd),
    .i_bus_data(i_bus_data), .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    i_rd_cmd   = 1'b0;
    i_bus_ack  = 1'b0;
    i_bus_err  = 1'b0;
    i_addr     = 32'h0;
    i_bus_data = 32'h0;
  endtask

  task automatic apply_reset();
    quiet_inputs();
    nrst = 1'b0;
    repeat (2) next_cycle();
    nrst = 1'b1;
    next_cycle();
    model_instr = 32'h0;
    exp_q.delete();
  endtask

  // One complete fetch transaction on u_dut. err_mode: 0 ack, 1 err only,
  // 2 err with ack. noise: issue an ignored strobe to a random address in
  // every WAIT cycle. Returns in the cycle after completion.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int delay, input int err_mode, input bit noise);
    logic        al;
    logic [31:0] got;
    al = (addr[1:0] == 2'b00);
    i_addr = addr;
    i_rd_cmd = 1'b1;
    i_bus_ack = 1'b0;
    i_bus_err = 1'b0;
    i_bus_data = $urandom;
    #1;
    n_checks++;
    if (o_busy !== al || o_bus_rd !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_req: busy=%b bus_rd=%b want busy=%b bus_rd=0", o_busy, o_bus_rd, al);
    end
    next_cycle();
    i_rd_cmd = 1'b0;
    if (!al) begin
      #1;
      n_checks++;
      if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b0010 || o_instr_dat !== model_instr) begin
        n_errors++;
        $display("FAIL misalign_resp: rd/busy/align/bus=%b instr=%h want 0010 instr=%h",
                 {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_instr_dat, model_instr);
      end
      return;
    end
    for (int k = 0; k <= delay; k++) begin
      i_rd_cmd   = noise;
      i_addr     = noise ? $urandom : addr;
      i_bus_err  = (k == delay) && (err_mode != 0);
      i_bus_ack  = (k == delay) && (err_mode != 1);
      i_bus_data = data;
      #1;
      n_checks++;
      if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b1100 || o_bus_addr !== addr ||
          o_instr_dat !== model_instr) begin
        n_errors++;
        $display("FAIL wait_cycle%0d: rd/busy/align/bus=%b addr=%h instr=%h want 1100 addr=%h instr=%h",
                 k, {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_bus_addr, o_instr_dat, addr, model_instr);
      end
      next_cycle();
    end
    quiet_inputs();
    model_instr = (err_mode != 0) ? 32'h0 : data;
    exp_q.push_back(model_instr);
    #1;
    got = exp_q.pop_front();
    n_checks++;
    if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== {3'b000, err_mode != 0} || o_instr_dat !== got) begin
      n_errors++;
      $display("FAIL fetch_done: rd/busy/align/bus=%b instr=%h want %b instr=%h",
               {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_instr_dat, {3'b000, err_mode != 0}, got);
    end
  endtask

  // Idle cycles on u_dut: no request, no pulses, data held.
  task automatic idle_check(input int n);
    quiet_inputs();
    for (int k = 0; k < n; k++) begin
      next_cycle();
      n_checks++;
      if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b0000 || o_instr_dat !== model_instr) begin
        n_errors++;
        $display("FAIL idle%0d: rd/busy/align/bus=%b instr=%h want 0000 instr=%h",
                 k, {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_instr_dat, model_instr);
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    quiet_inputs();
    repeat (2) next_cycle();
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b0000 || o_bus_addr !== 32'h0 ||
        o_instr_dat !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_main: rd/busy/align/bus=%b addr=%h instr=%h want 0000 0 0",
               {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_bus_addr, o_instr_dat);
    end
    n_checks++;
    if ({t_bus_rd, t_busy, t_err_align, t_err_bus} !== 4'b0000 || t_bus_addr !== 32'h0 ||
        t_instr_dat !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_to: rd/busy/align/bus=%b addr=%h instr=%h want 0000 0 0",
               {t_bus_rd, t_busy, t_err_align, t_err_bus}, t_bus_addr, t_instr_dat);
    end
    next_cycle();
    nrst = 1'b1;
    model_instr = 32'h0;
    idle_check(2);
  endtask

  task automatic test_basic_fetch();
    do_fetch(32'h0000_0100, 32'h2408_0005, 0, 0, 1'b0);
    idle_check(2);
  endtask

  task automatic test_misaligned();
    do_fetch(32'h0000_0102, $urandom, 0, 0, 1'b0);
    idle_check(2);
    do_fetch(32'h0000_0203, $urandom, 0, 0, 1'b0);
    idle_check(1);
  endtask

  task automatic test_delayed_ack();
    do_fetch(32'h0000_2000, 32'hDEAD_BEEF, 4, 0, 1'b1);
    idle_check(2);
  endtask

  task automatic test_ack_err_same();
    do_fetch(32'h0000_0300, 32'h1234_5678, 1, 0, 1'b0);
    do_fetch(32'h0000_0304, 32'hCAFE_F00D, 0, 2, 1'b0);
    idle_check(2);
    do_fetch(32'h0000_0308, 32'h0BAD_0BAD, 2, 1, 1'b0);
    idle_check(1);
  endtask

  task automatic test_idle_ack_ignored();
    do_fetch(32'h0000_0400, 32'h5555_AAAA, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      i_rd_cmd   = 1'b0;
      i_bus_ack  = 1'b1;
      i_bus_err  = (k == 1);
      i_bus_data = $urandom;
      next_cycle();
      n_checks++;
      if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b0000 || o_instr_dat !== model_instr) begin
        n_errors++;
        $display("FAIL idle_ack%0d: rd/busy/align/bus=%b instr=%h want 0000 instr=%h",
                 k, {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_instr_dat, model_instr);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    apply_reset();
    // Ack in the last allowed WAIT cycle still completes normally.
    d = 32'hA5A5_0001;
    i_addr = 32'h0000_0040;
    i_rd_cmd = 1'b1;
    next_cycle();
    i_rd_cmd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_bus_ack  = (k == 3);
      i_bus_data = d;
      #1;
      n_checks++;
      if (t_bus_rd !== 1'b1 || t_busy !== 1'b1 || t_err_bus !== 1'b0) begin
        n_errors++;
        $display("FAIL to_edge_wait%0d: bus_rd=%b busy=%b err_bus=%b want 1 1 0", k, t_bus_rd, t_busy, t_err_bus);
      end
      next_cycle();
    end
    quiet_inputs();
    #1;
    n_checks++;
    if ({t_bus_rd, t_busy, t_err_align, t_err_bus} !== 4'b0000 || t_instr_dat !== d) begin
      n_errors++;
      $display("FAIL to_edge_done: rd/busy/align/bus=%b instr=%h want 0000 instr=%h",
               {t_bus_rd, t_busy, t_err_align, t_err_bus}, t_instr_dat, d);
    end
    // No response at all: four request cycles, then NOP with a bus error.
    i_addr = 32'h0000_0044;
    i_rd_cmd = 1'b1;
    next_cycle();
    i_rd_cmd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (t_bus_rd !== 1'b1 || t_bus_addr !== 32'h0000_0044 || t_err_bus !== 1'b0) begin
        n_errors++;
        $display("FAIL to_wait%0d: bus_rd=%b addr=%h err_bus=%b want 1 00000044 0", k, t_bus_rd, t_bus_addr, t_err_bus);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if ({t_bus_rd, t_busy, t_err_align, t_err_bus} !== 4'b0001 || t_instr_dat !== 32'h0) begin
      n_errors++;
      $display("FAIL to_fire: rd/busy/align/bus=%b instr=%h want 0001 instr=0",
               {t_bus_rd, t_busy, t_err_align, t_err_bus}, t_instr_dat);
    end
    next_cycle();
    n_checks++;
    if ({t_bus_rd, t_busy, t_err_align, t_err_bus} !== 4'b0000) begin
      n_errors++;
      $display("FAIL to_after: rd/busy/align/bus=%b want 0000", {t_bus_rd, t_busy, t_err_align, t_err_bus});
    end
    apply_reset();
  endtask

  task automatic test_reset_in_wait();
    do_fetch(32'h0000_0500, 32'h7777_1111, 0, 0, 1'b0);
    i_addr = 32'h0000_0504;
    i_rd_cmd = 1'b1;
    next_cycle();
    i_rd_cmd = 1'b0;
    next_cycle();
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b0000 || o_bus_addr !== 32'h0 ||
        o_instr_dat !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_wait: rd/busy/align/bus=%b addr=%h instr=%h want 0000 0 0",
               {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_bus_addr, o_instr_dat);
    end
    next_cycle();
    nrst = 1'b1;
    model_instr = 32'h0;
    next_cycle();
    i_bus_ack = 1'b1;
    i_bus_data = 32'hFFFF_0000;
    next_cycle();
    quiet_inputs();
    #1;
    n_checks++;
    if ({o_bus_rd, o_busy, o_err_align, o_err_bus} !== 4'b0000 || o_bus_addr !== 32'h0 ||
        o_instr_dat !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_late_ack: rd/busy/align/bus=%b addr=%h instr=%h want 0000 0 0",
               {o_bus_rd, o_busy, o_err_align, o_err_bus}, o_bus_addr, o_instr_dat);
    end
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h0000_0600, 32'h0101_0101, 0, 0, 1'b0);
    do_fetch(32'h0000_0604, 32'h0202_0202, 0, 0, 1'b0);
    do_fetch(32'h0000_0609, 32'h0303_0303, 0, 0, 1'b0);
    do_fetch(32'h0000_060C, 32'h0404_0404, 1, 1, 1'b0);
    do_fetch(32'h0000_0610, 32'h0505_0505, 0, 0, 1'b0);
    idle_check(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          em;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      em = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_fetch(a, $urandom, $urandom_range(0, 6), em, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_check($urandom_range(1, 2));
    end
    idle_check(1);
  endtask

  initial begin
    quiet_inputs();
    nrst = 1'b1;
    model_instr = 32'h0;
    test_reset();
    test_basic_fetch();
    test_misaligned();
    test_delayed_ack();
    test_ack_err_same();
    test_idle_ack_ignored();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
